acc_addr_seq: RTL

ACC_ADDR_SEQ -- requirements
Module: acc_addr_seq

---
 rtl/acc_addr_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/acc_addr_seq.sv
// acc_addr_seq: walks the K x K psum window of every output pixel, issuing reads and SFU clear/accumulate strobes.
// Define ACC_SEQ_HOLD_EN to let the hold input stall the sequence.
module acc_addr_seq #(
  parameter int unsigned IN_W = 6,
  parameter int unsigned K    = 3,
  parameter int unsigned A_BW = 11
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         hold,
  output logic                                         busy,
  output logic                                         CEN_pmem,
  output logic                                         WEN_pmem,
  output logic [A_BW-1:0]                              A_pmem,
  output logic                                         acc,
  output logic                                         sfu_clr,
  output logic                                         out_valid,
  output logic [$clog2((IN_W-K+1)*(IN_W-K+1))-1:0]     o_idx,
  output logic                                         done
);

  localparam int unsigned OUT_W = IN_W - K + 1;
  localparam int unsigned NPIX  = OUT_W * OUT_W;
  localparam int unsigned OI_W  = $clog2(NPIX);
  localparam int unsigned OW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {IDLE, CLR, READ, DRAIN, VALID, DONE} state_t;

  state_t          state;
  logic [KW-1:0]   ki, kj, ki_nxt, kj_nxt;
  logic [OW-1:0]   orow, ocol;
  logic            stall;

`ifdef ACC_SEQ_HOLD_EN
  assign stall = hold;
`else
  logic hold_unused;
  assign hold_unused = hold;
  assign stall       = 1'b0;
`endif

  assign WEN_pmem = 1'b1;

  always_comb begin
    ki_nxt = ki;
    kj_nxt = kj + 1'b1;
    if (kj == KW'(K - 1)) begin
      kj_nxt = '0;
      ki_nxt = ki + 1'b1;
    end
  end

  function automatic logic [A_BW-1:0] pix_addr(input logic [OW-1:0] r, input logic [OW-1:0] c,
                                               input logic [KW-1:0] i, input logic [KW-1:0] j);
    logic [A_BW-1:0] kij;
    kij = A_BW'(i) * A_BW'(K) + A_BW'(j);
    return kij * A_BW'(IN_W * IN_W) + (A_BW'(r) + A_BW'(i)) * A_BW'(IN_W) + A_BW'(c) + A_BW'(j);
  endfunction

  // Outputs are loaded together with the state they belong to; a stall cycle
  // presents a bubble and leaves state/counters untouched so the step repeats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ki        <= '0;
      kj        <= '0;
      orow      <= '0;
      ocol      <= '0;
      o_idx     <= '0;
      busy      <= 1'b0;
      CEN_pmem  <= 1'b1;
      A_pmem    <= '0;
      acc       <= 1'b0;
      sfu_clr   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      acc       <= ~CEN_pmem;
      CEN_pmem  <= 1'b1;
      A_pmem    <= '0;
      sfu_clr   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (!stall) begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= CLR;
              sfu_clr <= 1'b1;
              busy    <= 1'b1;
            end
          end
          CLR: begin
            state    <= READ;
            ki       <= '0;
            kj       <= '0;
            CEN_pmem <= 1'b0;
            A_pmem   <= pix_addr(orow, ocol, '0, '0);
          end
          READ: begin
            if (ki == KW'(K - 1) && kj == KW'(K - 1)) begin
              state <= DRAIN;
            end else begin
              ki       <= ki_nxt;
              kj       <= kj_nxt;
              CEN_pmem <= 1'b0;
              A_pmem   <= pix_addr(orow, ocol, ki_nxt, kj_nxt);
            end
          end
          DRAIN: begin
            state     <= VALID;
            out_valid <= 1'b1;
          end
          VALID: begin
            if (o_idx == OI_W'(NPIX - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= CLR;
              sfu_clr <= 1'b1;
              o_idx   <= o_idx + 1'b1;
              if (ocol == OW'(OUT_W - 1)) begin
                ocol <= '0;
                orow <= orow + 1'b1;
              end else begin
                ocol <= ocol + 1'b1;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
            orow  <= '0;
            ocol  <= '0;
            o_idx <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
